// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded instruction from ID, registered copy toward EX,
// plus hazard/perf observation outputs.
interface id_ex_stage_reg_if #(
  parameter int size   = 32,
  parameter int CTRL_W = 16
);
  logic              buble;
  logic              flush;
  logic              stall;
  logic              valid_ID;
  logic [size-1:0]   PC_ID;
  logic [size-1:0]   A_ID;
  logic [size-1:0]   B_ID;
  logic [size-1:0]   IMM_ID;
  logic [4:0]        RA_ID;
  logic [4:0]        RB_ID;
  logic [4:0]        RD_ID;
  logic              isLoad_ID;
  logic [CTRL_W-1:0] CTRL_ID;

  logic              valid_EX;
  logic [size-1:0]   PC_EX;
  logic [size-1:0]   A_EX;
  logic [size-1:0]   B_EX;
  logic [size-1:0]   IMM_EX;
  logic [4:0]        RA_EX;
  logic [4:0]        RB_EX;
  logic [4:0]        RD_EX;
  logic              isLoad_EX;
  logic [CTRL_W-1:0] CTRL_EX;
  logic              hazard_err;
  logic [31:0]       bubble_cnt;
  logic [31:0]       flush_cnt;

  modport master (
    output buble, flush, stall, valid_ID, PC_ID, A_ID, B_ID, IMM_ID,
           RA_ID, RB_ID, RD_ID, isLoad_ID, CTRL_ID,
    input  valid_EX, PC_EX, A_EX, B_EX, IMM_EX, RA_EX, RB_EX, RD_EX,
           isLoad_EX, CTRL_EX, hazard_err, bubble_cnt, flush_cnt
  );

  modport slave (
    input  buble, flush, stall, valid_ID, PC_ID, A_ID, B_ID, IMM_ID,
           RA_ID, RB_ID, RD_ID, isLoad_ID, CTRL_ID,
    output valid_EX, PC_EX, A_EX, B_EX, IMM_EX, RA_EX, RB_EX, RD_EX,
           isLoad_EX, CTRL_EX, hazard_err, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush > stall > bubble > load priority and a load-use
// bubble watchdog. Define PERF_CNT_EN to implement the bubble/flush performance counters.
module id_ex_stage_reg #(
  parameter int size       = 32,
  parameter int CTRL_W     = 16,
  parameter int MAX_BUBBLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_stage_reg_if.slave  bus
);

  localparam int BCNT_RAW = $clog2(MAX_BUBBLE + 2);
  localparam int BCNT_W   = (BCNT_RAW < 2) ? 2 : BCNT_RAW;
  localparam logic [BCNT_W-1:0] BCNT_SAT = BCNT_W'(MAX_BUBBLE + 1);
  localparam logic [BCNT_W:0]   BCNT_MAX = (BCNT_W + 1)'(MAX_BUBBLE);

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_t;

  act_t act;

  always_comb begin
    act = ACT_LOAD;
    if (bus.flush)      act = ACT_FLUSH;
    else if (bus.stall) act = ACT_HOLD;
    else if (bus.buble) act = ACT_BUBBLE;
  end

  logic              valid_q;
  logic [size-1:0]   pc_q;
  logic [size-1:0]   a_q;
  logic [size-1:0]   b_q;
  logic [size-1:0]   imm_q;
  logic [4:0]        ra_q;
  logic [4:0]        rb_q;
  logic [4:0]        rd_q;
  logic              is_load_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Operand/PC fields follow ID even on a NOP; only the fields hazard detection and
  // later stages act on are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
    end else if (act != ACT_HOLD) begin
      pc_q  <= bus.PC_ID;
      a_q   <= bus.A_ID;
      b_q   <= bus.B_ID;
      imm_q <= bus.IMM_ID;
      ra_q  <= bus.RA_ID;
      rb_q  <= bus.RB_ID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
    end else begin
      case (act)
        ACT_LOAD: begin
          valid_q   <= bus.valid_ID;
          ctrl_q    <= bus.CTRL_ID;
          rd_q      <= bus.RD_ID;
          is_load_q <= bus.isLoad_ID;
        end
        ACT_HOLD: begin
          valid_q   <= valid_q;
          ctrl_q    <= ctrl_q;
          rd_q      <= rd_q;
          is_load_q <= is_load_q;
        end
        default: begin
          valid_q   <= 1'b0;
          ctrl_q    <= {CTRL_W{1'b0}};
          rd_q      <= 5'd0;
          is_load_q <= 1'b0;
        end
      endcase
    end
  end

  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W:0]   bcnt_inc;
  logic              hazard_err_q;

  assign bcnt_inc = {1'b0, bcnt} + 1'b1;

  // Stalled bubbles neither advance nor clear the run; only buble=0 ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt         <= '0;
      hazard_err_q <= 1'b0;
    end else if (!bus.buble) begin
      bcnt <= '0;
    end else if (!bus.stall) begin
      if (bcnt != BCNT_SAT) bcnt <= bcnt_inc[BCNT_W-1:0];
      if (bcnt_inc > BCNT_MAX) hazard_err_q <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (act == ACT_BUBBLE) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (act == ACT_FLUSH)  flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`else
  assign bus.bubble_cnt = 32'd0;
  assign bus.flush_cnt  = 32'd0;
`endif

  assign bus.valid_EX   = valid_q;
  assign bus.PC_EX      = pc_q;
  assign bus.A_EX       = a_q;
  assign bus.B_EX       = b_q;
  assign bus.IMM_EX     = imm_q;
  assign bus.RA_EX      = ra_q;
  assign bus.RB_EX      = rb_q;
  assign bus.RD_EX      = rd_q;
  assign bus.isLoad_EX  = is_load_q;
  assign bus.CTRL_EX    = ctrl_q;
  assign bus.hazard_err = hazard_err_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized bench for id_ex_stage_reg with a reference model of the stage's
// priority rules, plus directed scenarios with literal expectations.
module tb_id_ex_stage_reg;
  localparam int MAXB = 2;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  id_ex_stage_reg_if #(.size(32), .CTRL_W(16)) bus ();

  id_ex_stage_reg #(.size(32), .CTRL_W(16), .MAX_BUBBLE(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  ra, rb, rd;
    logic        ld;
    logic [15:0] ctrl;
  } ex_t;

  ex_t         m_ex  = '{default: '0};
  bit          m_dc  = 0;
  int          m_run = 0;
  bit          m_err = 0;
  logic [31:0] m_bub = 0;
  logic [31:0] m_fl  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ex_t id_snapshot();
    ex_t e;
    e.valid = bus.valid_ID; e.pc = bus.PC_ID; e.a = bus.A_ID; e.b = bus.B_ID;
    e.imm = bus.IMM_ID; e.ra = bus.RA_ID; e.rb = bus.RB_ID; e.rd = bus.RD_ID;
    e.ld = bus.isLoad_ID; e.ctrl = bus.CTRL_ID;
    return e;
  endfunction

  always @(negedge rst_n) begin
    m_ex = '{default: '0}; m_dc = 0; m_run = 0; m_err = 0; m_bub = 0; m_fl = 0;
  end

  // Reference: decide the edge's action from the priority list, then the watchdog run.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.flush || (!bus.stall && bus.buble)) begin
        m_ex = id_snapshot();
        m_ex.valid = 0; m_ex.ctrl = 0; m_ex.rd = 0; m_ex.ld = 0;
        m_dc = 1;
        if (bus.flush) m_fl = m_fl + 1;
        else           m_bub = m_bub + 1;
      end else if (!bus.stall) begin
        m_ex = id_snapshot();
        m_dc = 0;
      end
      if (!bus.buble) m_run = 0;
      else if (!bus.stall) begin
        m_run = m_run + 1;
        if (m_run > MAXB) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_EX", bus.valid_EX, m_ex.valid);
      chk("CTRL_EX", bus.CTRL_EX, m_ex.ctrl);
      chk("RD_EX", bus.RD_EX, m_ex.rd);
      chk("isLoad_EX", bus.isLoad_EX, m_ex.ld);
      chk("hazard_err", bus.hazard_err, m_err);
      chk("bubble_cnt", bus.bubble_cnt, PERF ? m_bub : 32'd0);
      chk("flush_cnt", bus.flush_cnt, PERF ? m_fl : 32'd0);
      if (!m_dc) begin
        chk("PC_EX", bus.PC_EX, m_ex.pc);
        chk("A_EX", bus.A_EX, m_ex.a);
        chk("B_EX", bus.B_EX, m_ex.b);
        chk("IMM_EX", bus.IMM_EX, m_ex.imm);
        chk("RA_EX", bus.RA_EX, m_ex.ra);
        chk("RB_EX", bus.RB_EX, m_ex.rb);
      end
    end
  end

  task automatic drive_idle();
    bus.buble = 0; bus.flush = 0; bus.stall = 0; bus.valid_ID = 0;
    bus.PC_ID = 0; bus.A_ID = 0; bus.B_ID = 0; bus.IMM_ID = 0;
    bus.RA_ID = 0; bus.RB_ID = 0; bus.RD_ID = 0; bus.isLoad_ID = 0; bus.CTRL_ID = 0;
  endtask

  task automatic at_drive();
    @(negedge clk); #1;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    at_drive();
    rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic drive_random();
    bus.flush     = ($urandom_range(0, 9) == 0);
    bus.stall     = ($urandom_range(0, 4) == 0);
    bus.buble     = ($urandom_range(0, 3) == 0);
    bus.valid_ID  = ($urandom_range(0, 4) != 0);
    bus.PC_ID     = $urandom; bus.A_ID = $urandom; bus.B_ID = $urandom; bus.IMM_ID = $urandom;
    bus.RA_ID     = 5'($urandom); bus.RB_ID = 5'($urandom); bus.RD_ID = 5'($urandom);
    bus.isLoad_ID = 1'($urandom);
    bus.CTRL_ID   = 16'($urandom);
  endtask

  initial begin
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    at_drive();
    rst_n = 1;
    chk_en = 1;

    // Reset value pins
    chk("rst valid_EX", bus.valid_EX, 0);
    chk("rst RD_EX", bus.RD_EX, 0);
    chk("rst hazard_err", bus.hazard_err, 0);

    // Normal load
    at_drive();
    bus.valid_ID = 1; bus.RD_ID = 7; bus.isLoad_ID = 1; bus.A_ID = 32'h1234;
    after_edge();
    chk("load RD_EX", bus.RD_EX, 7);
    chk("load isLoad_EX", bus.isLoad_EX, 1);
    chk("load A_EX", bus.A_EX, 32'h1234);
    chk("load valid_EX", bus.valid_EX, 1);

    // Asynchronous reset with EX loaded
    at_drive();
    bus.RD_ID = 5; bus.CTRL_ID = 16'h00ff;
    after_edge();
    chk("pre-rst RD_EX", bus.RD_EX, 5);
    #2 rst_n = 0;
    #1;
    chk("async rst RD_EX", bus.RD_EX, 0);
    chk("async rst valid_EX", bus.valid_EX, 0);
    chk("async rst A_EX", bus.A_EX, 0);
    chk("async rst CTRL_EX", bus.CTRL_EX, 0);
    at_drive();
    rst_n = 1;

    // Load-use bubble
    drive_idle();
    do_reset();
    bus.valid_ID = 1; bus.RD_ID = 3; bus.isLoad_ID = 1; bus.CTRL_ID = 16'h0101;
    after_edge();
    chk("lu load RD_EX", bus.RD_EX, 3);
    at_drive();
    bus.RA_ID = 3; bus.RD_ID = 9; bus.isLoad_ID = 0; bus.CTRL_ID = 16'h5a5a; bus.buble = 1;
    after_edge();
    chk("lu valid_EX", bus.valid_EX, 0);
    chk("lu CTRL_EX", bus.CTRL_EX, 0);
    chk("lu RD_EX", bus.RD_EX, 0);
    chk("lu isLoad_EX", bus.isLoad_EX, 0);
    chk("lu bubble_cnt", bus.bubble_cnt, PERF ? 32'd1 : 32'd0);
    at_drive();
    bus.buble = 0;
    after_edge();
    chk("lu reload valid_EX", bus.valid_EX, 1);
    chk("lu reload RA_EX", bus.RA_EX, 3);
    chk("lu reload RD_EX", bus.RD_EX, 9);
    chk("lu reload CTRL_EX", bus.CTRL_EX, 16'h5a5a);

    // Flush beats stall and bubble
    drive_idle();
    do_reset();
    bus.valid_ID = 1; bus.RD_ID = 6; bus.CTRL_ID = 16'hffff;
    bus.flush = 1; bus.stall = 1; bus.buble = 1;
    after_edge();
    chk("fp valid_EX", bus.valid_EX, 0);
    chk("fp RD_EX", bus.RD_EX, 0);
    chk("fp flush_cnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("fp bubble_cnt", bus.bubble_cnt, 0);

    // Stall hold, with a bubble request buried in it
    drive_idle();
    do_reset();
    bus.valid_ID = 1; bus.A_ID = 32'haaaa; bus.RD_ID = 4; bus.CTRL_ID = 16'h0011;
    after_edge();
    for (int i = 0; i < 3; i++) begin
      at_drive();
      bus.stall = 1; bus.buble = (i == 1);
      bus.A_ID = $urandom; bus.RD_ID = 5'(i + 10); bus.valid_ID = 0; bus.CTRL_ID = 16'h7777;
      after_edge();
      chk("stall A_EX", bus.A_EX, 32'haaaa);
      chk("stall RD_EX", bus.RD_EX, 4);
      chk("stall valid_EX", bus.valid_EX, 1);
      chk("stall CTRL_EX", bus.CTRL_EX, 16'h0011);
      chk("stall hazard_err", bus.hazard_err, 0);
      chk("stall bubble_cnt", bus.bubble_cnt, 0);
    end

    // Watchdog: third unstalled consecutive bubble trips it, sticky until reset
    drive_idle();
    do_reset();
    bus.buble = 1;
    for (int i = 1; i <= 3; i++) begin
      after_edge();
      chk("wd hazard_err", bus.hazard_err, (i == 3) ? 1'b1 : 1'b0);
    end
    at_drive();
    bus.buble = 0;
    after_edge();
    chk("wd sticky", bus.hazard_err, 1);
    at_drive();
    rst_n = 0;
    #1 chk("wd reset clears", bus.hazard_err, 0);
    #1 rst_n = 1;

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      at_drive();
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
      drive_random();
    end
    at_drive();
    drive_idle();
    repeat (2) @(negedge clk);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the Zero-RISC-V core, directly downstream of hazard detection. Captures decoded operands and control from ID each cycle. Converts a load-use `buble` request into a NOP in EX, and applies branch flush and global stall with fixed priority. Drives `RD_EX` and `isLoad_EX` back to hazard detection and optionally counts bubbles and flushes.

## Interface

Parameters:
- `size`, 32: data/PC width.
- `CTRL_W`, 16: width of packed EX/MEM/WB control bundle.
- `MAX_BUBBLE`, 2: consecutive-bubble limit before `hazard_err` sets.

Ports (one clock; reset asynchronous, active-low):
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `buble` in 1: load-use bubble request from hazard detection.
- `flush` in 1: branch/jump redirect; kill instruction entering EX.
- `stall` in 1: global hold (memory wait); register keeps contents.
- `valid_ID` in 1: ID holds a real instruction.
- `PC_ID` in size: instruction PC.
- `A_ID`, `B_ID`, `IMM_ID` in size: operand A, operand B, immediate.
- `RA_ID`, `RB_ID`, `RD_ID` in 5: source/destination register indices.
- `isLoad_ID` in 1: instruction is a load.
- `CTRL_ID` in CTRL_W: control bundle.
- `valid_EX` out 1, `PC_EX`, `A_EX`, `B_EX`, `IMM_EX` out size, `RA_EX`, `RB_EX`, `RD_EX` out 5, `isLoad_EX` out 1, `CTRL_EX` out CTRL_W: registered copies.
- `hazard_err` out 1: sticky; bubble asserted more than MAX_BUBBLE consecutive cycles.
- `bubble_cnt`, `flush_cnt` out 32: performance counters.

## Operation

- All outputs registered; update on rising `clk` only.
- Per-edge action, highest priority first:
  - **Flush:** `flush`=1 → load NOP.
  - **Stall:** `stall`=1 → hold all EX outputs.
  - **Bubble:** `buble`=1 → load NOP.
  - **Load:** otherwise → load ID values; `valid_EX`=`valid_ID`.
- NOP definition: `valid_EX`=0, `CTRL_EX`=0, `RD_EX`=0, `isLoad_EX`=0. PC/A/B/IMM/RA/RB still load from ID (debug only, don't-care).
- Forcing `RD_EX`=0 and `isLoad_EX`=0 on NOP guarantees the hazard unit drops `buble` the next cycle.
- Bubble watchdog:
  - 2-bit-minimum saturating counter `bcnt`.
  - Increments on each edge where `buble`=1 and `stall`=0; clears on any edge with `buble`=0.
  - When `bcnt` would exceed MAX_BUBBLE, `hazard_err` sets and stays set until reset.
  - Flush does not clear `bcnt`.
- Counters (see Configuration):
  - `bubble_cnt` +1 on each Bubble action that is actually taken.
  - `flush_cnt` +1 on each Flush action.
  - 32-bit; wrap 0xFFFFFFFF → 0.
  - Not affected by stall except that a stalled bubble is not counted.

## Timing

- Latency: 1 cycle ID → EX.
- `buble` and `flush` are sampled at the rising edge and must be stable before it. The hazard unit's negedge update satisfies this.
- Reset: all outputs 0, `hazard_err`=0, counters 0, `bcnt`=0. This takes effect immediately on `rst_n` fall, independent of `clk`.
- Reset deasserting mid-operation: first edge after release performs a normal Load.
- Simultaneous events:
  - `flush`+`stall` → NOP (flush wins).
  - `stall`+`buble` → hold; no count; `bcnt` unchanged.
  - `flush`+`buble` → NOP; `flush_cnt` +1; `bubble_cnt` unchanged.

## Configuration

- `PERF_CNT_EN` defined: `bubble_cnt` and `flush_cnt` are implemented as above.
- `PERF_CNT_EN` not defined: no counter flops; both ports tied to 0.
- The watchdog is unconditional in both builds.

## Test plan

- **Reset:** assert `rst_n`=0 mid-cycle with EX loaded (`RD_EX`=5, `valid_EX`=1) → all outputs 0 immediately, before the next edge.
- **Normal load:** `valid_ID`=1, `RD_ID`=7, `isLoad_ID`=1, `A_ID`=0x1234, no controls → next edge `RD_EX`=7, `isLoad_EX`=1, `A_EX`=0x1234, `valid_EX`=1.
- **Load-use:** load to x3 in EX; ID has `RA_ID`=3 and `buble`=1 → `valid_EX`=0, `CTRL_EX`=0, `RD_EX`=0. The hazard unit then drops `buble` and the held ID instruction loads on the following edge. `bubble_cnt`=1 with PERF_CNT_EN, 0 without.
- **Flush priority:** `flush`=1, `stall`=1, `buble`=1 together → NOP loaded, `flush_cnt`=1, `bubble_cnt`=0.
- **Stall hold:** `stall`=1 for 3 cycles with changing ID inputs → EX outputs constant; `buble`=1 during the stall → no count and no `hazard_err`.
- **Watchdog:** `buble` forced to 1 for 3 unstalled edges with MAX_BUBBLE=2 → `hazard_err` rises after the 3rd edge. It remains 1 after `buble`=0 and clears only on `rst_n`=0.
